// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// -----------------
// Lets two requesters share one single-port SRAM macro, for example a
// weight/activation loader (requester 0) and the MAC engine fetch path
// (requester 1). Grants are round-robin, with at most one access per cycle.
// Each requester may have at most one read outstanding. A requester cannot be
// granted a new read until its previous response has been popped, or is being
// popped in the same cycle.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   scan_en_i           test scan enable; while high, no grants are issued
//   req_valid_i[1:0]    request valid, per requester
//   req_ready_o[1:0]    request accepted (one-hot grant, combinational)
//   req_we_i[1:0]       1 = write, 0 = read
//   req_addr_i          word addresses; requester r uses slice r
//   req_wdata_i         write data; requester r uses slice r
//   rsp_valid_o[1:0]    registered read-response valid
//   rsp_ready_i[1:0]    read-response accepted
//   rsp_rdata_o         registered read data; requester r uses slice r
//   sram_ceb_o          macro chip enable, active-low
//   sram_web_o          macro write enable, active-low
//   sram_a_o, sram_d_o  macro address and write data (0 when idle)
//   sram_q_i            macro read data, valid the cycle after the access
//   sram_scan_en_o      scan_en_i forwarded to the macro
module sram_port_arbiter #(
  parameter int NUM_WORDS = 512,
  parameter int ADDR_W    = $clog2(NUM_WORDS),
  parameter int DATA_W    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scan_en_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [2*DATA_W-1:0]   rsp_rdata_o,
  output logic                  sram_ceb_o,
  output logic                  sram_web_o,
  output logic [ADDR_W-1:0]     sram_a_o,
  output logic [DATA_W-1:0]     sram_d_o,
  input  logic [DATA_W-1:0]     sram_q_i,
  output logic                  sram_scan_en_o
);

  // Round-robin pointer: index of the requester preferred when both are eligible.
  logic                ptr_q, ptr_d;
  // A read was issued last cycle; sram_q_i carries its data this cycle.
  logic [1:0]          inflight_q, inflight_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [1:0]          read_ok;
  logic [1:0]          elig;
  logic                gnt_any;
  logic                gnt_idx;

  // Arbitration
  always_comb begin
    // A new read needs the response slot to be free by the time data returns.
    // That is true when the slot is empty or is being popped this cycle.
    // Writes never use the slot, so they are never held back by it.
    read_ok = ~inflight_q & (~rsp_valid_q | rsp_ready_i);
    elig    = req_valid_i & {2{~scan_en_i}} & (req_we_i | read_ok);
    gnt_any = |elig;
    if (&elig) begin
      gnt_idx = ptr_q;
    end else begin
      gnt_idx = elig[1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready_o[gi] = gnt_any && (gnt_idx == 1'(gi));
    end
  endgenerate

  // Macro interface, driven combinationally from the grant
  always_comb begin
    sram_ceb_o = 1'b1;
    sram_web_o = 1'b1;
    sram_a_o   = '0;
    sram_d_o   = '0;
    if (gnt_any) begin
      sram_ceb_o = 1'b0;
      if (gnt_idx) begin
        sram_web_o = ~req_we_i[1];
        sram_a_o   = req_addr_i[2*ADDR_W-1:ADDR_W];
        sram_d_o   = req_wdata_i[2*DATA_W-1:DATA_W];
      end else begin
        sram_web_o = ~req_we_i[0];
        sram_a_o   = req_addr_i[ADDR_W-1:0];
        sram_d_o   = req_wdata_i[DATA_W-1:0];
      end
    end
  end

  assign sram_scan_en_o = scan_en_i;

  // Next state
  always_comb begin
    ptr_d       = ptr_q;
    inflight_d  = inflight_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    if (gnt_any) begin
      ptr_d = ~gnt_idx;
    end

    for (int r = 0; r < 2; r++) begin
      // When returning data and a pop land on the same edge, the load wins,
      // so a freshly loaded response is never lost.
      if (inflight_q[r]) begin
        rsp_valid_d[r]                   = 1'b1;
        rsp_rdata_d[r*DATA_W +: DATA_W]  = sram_q_i;
        inflight_d[r]                    = 1'b0;
      end else if (rsp_ready_i[r]) begin
        rsp_valid_d[r] = 1'b0;
      end
      if (gnt_any && (gnt_idx == 1'(r)) && !req_we_i[r]) begin
        inflight_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= 1'b0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// --------------------
// Testbench for sram_port_arbiter. It contains a behavioural SRAM macro, and a
// reference model with its own memory image, a round-robin pointer and one
// expected-response queue per requester. Inputs change 1 time unit after each
// rising edge. The monitor samples on the falling edge. Each cycle it checks
// responses against the queue heads, then predicts the grant from the
// arbitration rules and checks it.
module tb_sram_port_arbiter;

  localparam int NW = 512;
  localparam int AW = 9;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            scan_en_i = 1'b0;
  logic [1:0]      req_valid_i = '0;
  logic [1:0]      req_ready_o;
  logic [1:0]      req_we_i = '0;
  logic [2*AW-1:0] req_addr_i = '0;
  logic [2*DW-1:0] req_wdata_i = '0;
  logic [1:0]      rsp_valid_o;
  logic [1:0]      rsp_ready_i = '0;
  logic [2*DW-1:0] rsp_rdata_o;
  logic            sram_ceb_o;
  logic            sram_web_o;
  logic [AW-1:0]   sram_a_o;
  logic [DW-1:0]   sram_d_o;
  logic [DW-1:0]   sram_q_i = '0;
  logic            sram_scan_en_o;

  sram_port_arbiter #(.NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .scan_en_i      (scan_en_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .sram_ceb_o     (sram_ceb_o),
    .sram_web_o     (sram_web_o),
    .sram_a_o       (sram_a_o),
    .sram_d_o       (sram_d_o),
    .sram_q_i       (sram_q_i),
    .sram_scan_en_o (sram_scan_en_o)
  );

  always #5 clk = ~clk;

  // Behavioural single-port macro: write, or read with data valid next cycle.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (!sram_ceb_o) begin
      if (!sram_web_o) sram_mem[sram_a_o] <= sram_d_o;
      else             sram_q_i <= sram_mem[sram_a_o];
    end
  end

  // Reference model state
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] ref_mem [NW];
  exp_t          exp_q [2][$];
  int            ptr_m = 0;
  int            cyc = 0;
  bit            started = 0;
  bit            log_en = 1;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_i) begin
      started = 1;
      exp_q[0].delete();
      exp_q[1].delete();
      ptr_m = 0;
    end else if (started) begin
      bit [1:0]      elig_m;
      int            eg;
      logic [1:0]    exp_ready;
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;

      for (int r = 0; r < 2; r++) begin
        if (exp_q[r].size() > 0 && cyc >= exp_q[r][0].due) begin
          chk($sformatf("rsp_valid%0d", r), 64'(rsp_valid_o[r]), 64'd1);
          chk($sformatf("rsp_rdata%0d", r), 64'(rsp_rdata_o[r*DW +: DW]), 64'(exp_q[r][0].data));
          if (rsp_ready_i[r]) begin
            if (log_en)
              $display("cyc=%0d rsp r%0d data=%h", cyc, r, rsp_rdata_o[r*DW +: DW]);
            void'(exp_q[r].pop_front());
          end
        end else begin
          chk($sformatf("rsp_idle%0d", r), 64'(rsp_valid_o[r]), 64'd0);
        end
      end

      // A read is allowed only once the previous read of that requester is
      // completely retired, counting a pop made this cycle.
      for (int r = 0; r < 2; r++)
        elig_m[r] = req_valid_i[r] && !scan_en_i && (req_we_i[r] || exp_q[r].size() == 0);

      if (elig_m == 2'b11) eg = ptr_m;
      else if (elig_m[0])  eg = 0;
      else if (elig_m[1])  eg = 1;
      else                 eg = -1;

      exp_ready = (eg < 0) ? 2'b00 : 2'(1 << eg);
      ga        = (eg < 0) ? '0 : req_addr_i[eg*AW +: AW];
      gd        = (eg < 0) ? '0 : req_wdata_i[eg*DW +: DW];

      chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
      chk("sram_ceb", 64'(sram_ceb_o), 64'(eg < 0));
      chk("sram_web", 64'(sram_web_o), (eg < 0) ? 64'd1 : 64'(!req_we_i[eg]));
      chk("sram_a", 64'(sram_a_o), 64'(ga));
      chk("sram_d", 64'(sram_d_o), 64'(gd));
      chk("sram_scan_en", 64'(sram_scan_en_o), 64'(scan_en_i));

      if (eg >= 0) begin
        if (req_we_i[eg]) begin
          ref_mem[ga] = gd;
          if (log_en) $display("cyc=%0d grant r%0d write a=%h d=%h", cyc, eg, ga, gd);
        end else begin
          exp_q[eg].push_back('{data: ref_mem[ga], due: cyc + 2});
          if (log_en) $display("cyc=%0d grant r%0d read a=%h", cyc, eg, ga);
        end
        ptr_m = 1 - eg;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [1:0] v, input logic [1:0] we,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = {a1, a0};
    req_wdata_i = {d1, d0};
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end

    // Reset
    rst_i = 1;
    step(3);
    rst_i = 0;
    @(negedge clk);
    chk("reset_rdata", rsp_rdata_o, 64'd0);
    chk("reset_valid", 64'(rsp_valid_o), 64'd0);
    step(1);

    // Write 0x005, then read it back.
    rsp_ready_i = 2'b01;
    req(2'b01, 2'b01, 9'h005, 9'h000, 32'hDEADBEEF, 32'h0);
    step(1);
    req(2'b01, 2'b00, 9'h005, 9'h000, 32'h0, 32'h0);
    step(1);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    step(4);

    // Both requesters reading continuously; grants alternate starting at r0.
    rst_i = 1;
    step(1);
    rst_i = 0;
    rsp_ready_i = 2'b11;
    req(2'b11, 2'b00, 9'h010, 9'h1FF, 32'h0, 32'h0);
    step(12);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    step(3);

    // Response held unpopped: a second read is blocked, but a write is not.
    rsp_ready_i = 2'b00;
    req(2'b01, 2'b00, 9'h020, 9'h000, 32'h0, 32'h0);
    step(6);
    req(2'b01, 2'b01, 9'h021, 9'h000, 32'h12345678, 32'h0);
    step(1);
    req(2'b01, 2'b00, 9'h021, 9'h000, 32'h0, 32'h0);
    step(2);
    rsp_ready_i = 2'b01;
    step(4);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    step(3);

    // scan_en blocks all grants; grants resume from the current pointer.
    rsp_ready_i = 2'b11;
    req(2'b11, 2'b00, 9'h030, 9'h031, 32'h0, 32'h0);
    scan_en_i = 1;
    step(3);
    scan_en_i = 0;
    step(4);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    step(3);

    // Reset right after an r1 read grant: the in-flight read is discarded.
    req(2'b10, 2'b00, 9'h000, 9'h040, 32'h0, 32'h0);
    step(1);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    rst_i = 1;
    step(1);
    rst_i = 0;
    step(3);

    // Reset after an r0 grant: the pointer returns to r0.
    req(2'b01, 2'b01, 9'h041, 9'h000, 32'hA5A5A5A5, 32'h0);
    step(1);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    rst_i = 1;
    step(1);
    rst_i = 0;
    req(2'b11, 2'b00, 9'h041, 9'h042, 32'h0, 32'h0);
    step(1);
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    step(3);

    // Randomized traffic. A small address window makes read-after-write hits common.
    log_en = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a0, a1;
      a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      req(2'($urandom), 2'($urandom), a0, a1, $urandom, $urandom);
      rsp_ready_i = 2'($urandom);
      scan_en_i   = ($urandom_range(0, 19) == 0);
      step(1);
    end

    // Drain
    req(2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0);
    scan_en_i   = 0;
    rsp_ready_i = 2'b11;
    step(5);
    chk("drain_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 512x32 SRAM macro between two requesters, e.g. requester 0 = weight/activation loader, requester 1 = MAC engine fetch.
- Each requester has a valid/ready request channel and a registered valid/ready read-response channel.
- Arbitration is round-robin. The block drives the macro's active-low chip-enable and write-enable and its scan-enable gating input.
- Sits between the hwpe streamers and the SRAM instance inside the MAC engine.

Parameters:
- NUM_WORDS, 512, SRAM depth in words
- ADDR_W, $clog2(NUM_WORDS), address width
- DATA_W, 32, word width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- scan_en_i  in  1  test scan enable; blocks all grants
- req_valid_i  in  2  per-requester request valid
- req_ready_o  out  2  per-requester request accepted (grant)
- req_we_i  in  2  1 = write, 0 = read
- req_addr_i  in  2*ADDR_W  per-requester word address, requester r in slice r
- req_wdata_i  in  2*DATA_W  per-requester write data
- rsp_valid_o  out  2  per-requester read data valid
- rsp_ready_i  in  2  per-requester read data accepted
- rsp_rdata_o  out  2*DATA_W  per-requester read data
- sram_ceb_o  out  1  SRAM chip enable, active-low
- sram_web_o  out  1  SRAM write enable, active-low (0 = write)
- sram_a_o  out  ADDR_W  SRAM address
- sram_d_o  out  DATA_W  SRAM write data
- sram_q_i  in  DATA_W  SRAM read data, valid the cycle after the access
- sram_scan_en_o  out  1  forwarded scan_en_i

Behaviour:
- Reset (rst_i=1 at clk edge):
  - rsp_valid_o=0, rsp_rdata_o=0.
  - RR pointer=0 (requester 0 preferred).
  - Both inflight flags cleared; any in-flight read is discarded and never returned.
- SRAM-side outputs are combinational from the grant:
  - sram_ceb_o=1 and sram_web_o=1 whenever no grant.
  - sram_a_o/sram_d_o = granted requester's fields, 0 when idle.
  - sram_scan_en_o = scan_en_i.
- Eligibility of r: req_valid_i[r] & ~scan_en_i & (req_we_i[r] | read_ok[r]).
- read_ok[r] = ~inflight[r] & (~rsp_valid_o[r] | rsp_ready_i[r]). Max one outstanding read per requester.
- Grant (at most one per cycle):
  - Both eligible: grant = RR pointer.
  - One eligible: grant it.
  - req_ready_o[g]=1 only for granted g; combinational, no dependency of ready on valid of other requester beyond arbitration.
- Pointer update: after any grant to g, pointer = 1-g. No grant: unchanged.
- Access on grant: sram_ceb_o=0; sram_web_o = ~req_we_i[g].
- Read pipeline:
  - Cycle t: grant, inflight[g]<=1.
  - Cycle t+1: sram_q_i valid; at the t+1 edge, rsp_rdata_o[g]<=sram_q_i, rsp_valid_o[g]<=1, inflight[g]<=0.
  - Response visible in cycle t+2 (latency 2).
- rsp_valid_o[r] clears on rsp_ready_i[r] unless a new response loads the same edge (load wins).
- rsp_rdata_o[r] holds value until next load.
- Throughput:
  - Single requester reading: one read per 2 cycles.
  - Alternating requesters or writes: one access per cycle.
  - Writes never blocked by a pending response.
- Simultaneous read return for r and pop by r in same cycle: new data loaded, valid stays 1.
- scan_en_i rises with read in flight: response still captured and returned; new grants blocked while high.
- Address out of range (>= NUM_WORDS): passed through unmodified; no checking.

Test Plan:
- Reset, then r0 write addr 0x005 data 0xDEADBEEF, r0 read 0x005 -> sram_ceb_o=0, web_o=0 at grant cycle; rsp_valid_o[0]=1 with 0xDEADBEEF exactly 2 cycles after read grant.
- Both requesters continuously valid, reads to 0x010 (r0) and 0x1FF (r1), rsp_ready=11 -> grants alternate 0,1,0,1 starting with r0; one access every cycle; each response correct.
- r0 read outstanding, rsp_ready_i[0]=0 held 5 cycles, r0 issues second read -> req_ready_o[0]=0 until pop; first data held stable.
- r0 asserts write while r0 response still unpopped -> write granted immediately.
- scan_en_i=1 with both valid -> req_ready_o=00, sram_ceb_o=1, sram_scan_en_o=1; deassert -> grants resume from current pointer.
- rst_i pulsed the cycle after r1 read grant -> rsp_valid_o[1] stays 0; pointer returns to 0.
